// File: rtl/cl_stream_ctl_slv.sv
// Register slot for the streaming controller. It decodes the test-slot pulses
// and acks them one cycle later, and it holds the start/abort/finish/timeout FSM.
module cl_stream_ctl_slv #(
  parameter logic [31:0] DEFAULT_TIMEOUT = 32'd0,
  parameter logic [31:0] UNMAPPED_RDATA  = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic [31:0] tst_addr,
  input  logic [31:0] tst_wdata,
  input  logic        tst_wr,
  input  logic        tst_rd,
  output logic        tst_ack,
  output logic [31:0] tst_rdata,
  input  logic        beat_valid,
  input  logic        stream_finished,
  output logic        stream_start,
  output logic        streaming_active
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0] W_CTRL    = 6'h00;
  localparam logic [5:0] W_STATUS  = 6'h01;
  localparam logic [5:0] W_CYCLE   = 6'h02;
  localparam logic [5:0] W_TIMEOUT = 6'h03;
  localparam logic [5:0] W_BEAT    = 6'h04;
  localparam logic [5:0] W_SCRATCH = 6'h05;

  logic [1:0]  state_reg;
  logic [31:0] cycle_cnt_reg;
  logic [31:0] beat_cnt_reg;
  logic [31:0] timeout_limit_reg;
  logic [31:0] scratch_reg;
  logic        done_reg;
  logic        timeout_reg;
  logic        start_err_reg;

  logic [5:0]  word;
  logic        ctrl_wr;
  logic        status_wr;
  logic        start_req;
  logic        abort_req;
  logic        timeout_hit;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign word             = tst_addr[7:2];
  assign unused_addr_bits = ^{tst_addr[31:8], tst_addr[1:0]};
  assign ctrl_wr          = tst_wr && (word == W_CTRL);
  assign status_wr        = tst_wr && (word == W_STATUS);
  // Abort dominates: a CTRL write with both bits set never starts a run.
  assign start_req        = ctrl_wr && tst_wdata[0] && !tst_wdata[1];
  assign abort_req        = ctrl_wr && tst_wdata[1];
  assign timeout_hit      = (timeout_limit_reg != 32'd0) && (cycle_cnt_reg >= timeout_limit_reg);
  assign streaming_active = (state_reg == ST_RUN);

  always_comb begin
    rd_mux = UNMAPPED_RDATA;
    case (word)
      W_CTRL:    rd_mux = 32'd0;
      W_STATUS:  rd_mux = {27'd0, start_err_reg, timeout_reg, done_reg, state_reg};
      W_CYCLE:   rd_mux = cycle_cnt_reg;
      W_TIMEOUT: rd_mux = timeout_limit_reg;
      W_BEAT:    rd_mux = beat_cnt_reg;
      W_SCRATCH: rd_mux = scratch_reg;
      default:   rd_mux = UNMAPPED_RDATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_reg         <= ST_IDLE;
      cycle_cnt_reg     <= 32'd0;
      beat_cnt_reg      <= 32'd0;
      timeout_limit_reg <= DEFAULT_TIMEOUT;
      scratch_reg       <= 32'd0;
      done_reg          <= 1'b0;
      timeout_reg       <= 1'b0;
      start_err_reg     <= 1'b0;
      tst_ack           <= 1'b0;
      tst_rdata         <= 32'd0;
      stream_start      <= 1'b0;
    end else begin
      // Read data comes from the pre-edge registers, so wr+rd returns the old value.
      tst_ack      <= tst_wr || tst_rd;
      tst_rdata    <= tst_rd ? rd_mux : 32'd0;
      stream_start <= 1'b0;

      if (tst_wr && (word == W_TIMEOUT)) timeout_limit_reg <= tst_wdata;
      if (tst_wr && (word == W_SCRATCH)) scratch_reg       <= tst_wdata;

      // W1C goes first so that an FSM event on the same edge can re-set a bit.
      if (status_wr) begin
        if (tst_wdata[2]) done_reg      <= 1'b0;
        if (tst_wdata[3]) timeout_reg   <= 1'b0;
        if (tst_wdata[4]) start_err_reg <= 1'b0;
      end

      case (state_reg)
        ST_RUN: begin
          if (beat_valid && (beat_cnt_reg != 32'hffff_ffff))
            beat_cnt_reg <= beat_cnt_reg + 32'd1;
          if (start_req) start_err_reg <= 1'b1;
          if (abort_req) begin
            state_reg   <= ST_DONE;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
          end else if (stream_finished) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (timeout_hit) begin
            state_reg   <= ST_DONE;
            timeout_reg <= 1'b1;
          end else if (cycle_cnt_reg != 32'hffff_ffff) begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
          end
        end
        default: begin
          if (start_req) begin
            state_reg     <= ST_RUN;
            cycle_cnt_reg <= 32'd0;
            beat_cnt_reg  <= 32'd0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
            stream_start  <= 1'b1;
          end else if ((state_reg == ST_DONE) && status_wr && (tst_wdata[2] || tst_wdata[3])) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cl_stream_ctl_slv.sv
// Bench for cl_stream_ctl_slv: directed register traffic, an event-level model
// compared on every cycle, and literal expectations at each readback.
module tb_cl_stream_ctl_slv;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic [31:0] tst_addr;
  logic [31:0] tst_wdata;
  logic        tst_wr;
  logic        tst_rd;
  logic        tst_ack;
  logic [31:0] tst_rdata;
  logic        beat_valid;
  logic        stream_finished;
  logic        stream_start;
  logic        streaming_active;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cl_stream_ctl_slv dut (
    .clk              (clk),
    .sync_rst         (sync_rst),
    .tst_addr         (tst_addr),
    .tst_wdata        (tst_wdata),
    .tst_wr           (tst_wr),
    .tst_rd           (tst_rd),
    .tst_ack          (tst_ack),
    .tst_rdata        (tst_rdata),
    .beat_valid       (beat_valid),
    .stream_finished  (stream_finished),
    .stream_start     (stream_start),
    .streaming_active (streaming_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int          m_state;
  logic [31:0] m_cyc, m_beat, m_lim, m_scr;
  bit          m_done, m_to, m_err;
  bit          m_valid = 0;
  logic        e_ack, e_start, e_active;
  logic [31:0] e_rdata;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hfc;
    case (off)
      8'h00:   return 32'd0;
      8'h04:   return m_state | (m_done << 2) | (m_to << 3) | (m_err << 4);
      8'h08:   return m_cyc;
      8'h0c:   return m_lim;
      8'h10:   return m_beat;
      8'h14:   return m_scr;
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Apply one clock edge worth of behaviour, given the inputs held this cycle.
  task automatic m_step();
    logic [7:0] off;
    bit is_start, is_abort, is_status;
    int was;
    if (sync_rst) begin
      m_state = M_IDLE; m_cyc = 0; m_beat = 0; m_lim = 0; m_scr = 0;
      m_done = 0; m_to = 0; m_err = 0;
      e_ack = 0; e_rdata = 0; e_start = 0; e_active = 0;
      m_valid = 1;
      return;
    end
    off       = tst_addr[7:0] & 8'hfc;
    e_ack     = tst_wr | tst_rd;
    e_rdata   = tst_rd ? m_read(tst_addr) : 32'd0;
    e_start   = 0;
    is_start  = tst_wr && off == 8'h00 && tst_wdata[1:0] == 2'b01;
    is_abort  = tst_wr && off == 8'h00 && tst_wdata[1];
    is_status = tst_wr && off == 8'h04;
    was       = m_state;
    if (tst_wr && off == 8'h0c) m_lim = tst_wdata;
    if (tst_wr && off == 8'h14) m_scr = tst_wdata;
    if (is_status) begin
      if (tst_wdata[2]) m_done = 0;
      if (tst_wdata[3]) m_to = 0;
      if (tst_wdata[4]) m_err = 0;
    end
    if (was == M_RUN) begin
      if (beat_valid && m_beat < 32'hffff_ffff) m_beat++;
      if (is_start) m_err = 1;
      if (is_abort)                          begin m_state = M_DONE; m_done = 0; m_to = 0; end
      else if (stream_finished)              begin m_state = M_DONE; m_done = 1; end
      else if (m_lim != 0 && m_cyc >= m_lim) begin m_state = M_DONE; m_to = 1; end
      else if (m_cyc < 32'hffff_ffff)        m_cyc++;
    end else if (is_start) begin
      m_state = M_RUN; m_cyc = 0; m_beat = 0; m_done = 0; m_to = 0; e_start = 1;
    end else if (was == M_DONE && is_status && (tst_wdata[2] || tst_wdata[3])) begin
      m_state = M_IDLE;
    end
    e_active = (m_state == M_RUN);
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("cyc ack",    tst_ack,          e_ack);
        chk("cyc rdata",  tst_rdata,        e_rdata);
        chk("cyc start",  stream_start,     e_start);
        chk("cyc active", streaming_active, e_active);
      end
      m_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
    tst_wr = wr; tst_rd = rd; tst_addr = addr; tst_wdata = data;
    tick();
    tst_wr = 1'b0; tst_rd = 1'b0;
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data);
    req(1'b1, 1'b0, addr, data);
    chk({name, " ack"}, tst_ack, 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    req(1'b0, 1'b1, addr, 32'd0);
    chk({name, " ack"}, tst_ack, 32'd1);
    chk(name, tst_rdata, exp);
  endtask

  initial begin
    sync_rst = 1'b1; tst_addr = 0; tst_wdata = 0; tst_wr = 0; tst_rd = 0;
    beat_valid = 0; stream_finished = 0;
    repeat (3) tick();
    sync_rst = 1'b0;
    tick();
    chk("rst ack",    tst_ack,          32'd0);
    chk("rst start",  stream_start,     32'd0);
    chk("rst active", streaming_active, 32'd0);

    rd_chk("rd status",   32'h04, 32'h0);
    rd_chk("rd limit",    32'h0c, 32'h0);
    rd_chk("rd unmapped", 32'h3c, 32'hdead_beef);

    wr_chk("wr scratch", 32'h14, 32'ha5a5_1234);
    rd_chk("rd scratch", 32'h14, 32'ha5a5_1234);
    wr_chk("wr unmapped", 32'h3c, 32'h1111_1111);
    rd_chk("scratch kept", 32'h14, 32'ha5a5_1234);
    rd_chk("low addr bits", 32'h17, 32'ha5a5_1234);
    req(1'b1, 1'b1, 32'h14, 32'h1111_2222);
    chk("wr+rd ack", tst_ack, 32'd1);
    chk("wr+rd old", tst_rdata, 32'ha5a5_1234);
    rd_chk("wr+rd new", 32'h14, 32'h1111_2222);

    // normal run: 10 beats, finish once CYCLE_CNT has reached 20
    wr_chk("start", 32'h00, 32'h1);
    chk("start pulse", stream_start, 32'd1);
    chk("active run", streaming_active, 32'd1);
    for (int i = 0; i < 20; i++) begin
      beat_valid = (i < 10);
      tick();
    end
    beat_valid = 1'b0;
    chk("start once", stream_start, 32'd0);
    stream_finished = 1'b1;
    tick();
    stream_finished = 1'b0;
    chk("active done", streaming_active, 32'd0);
    rd_chk("status done", 32'h04, 32'h6);
    rd_chk("beat cnt",    32'h10, 32'd10);
    rd_chk("cycle cnt",   32'h08, 32'd20);
    stream_finished = 1'b1;
    tick();
    stream_finished = 1'b0;
    rd_chk("finish idle ign", 32'h04, 32'h6);
    wr_chk("clr done", 32'h04, 32'h4);
    rd_chk("status idle", 32'h04, 32'h0);

    // timeout run
    wr_chk("wr limit", 32'h0c, 32'd5);
    rd_chk("rd limit5", 32'h0c, 32'd5);
    wr_chk("start to", 32'h00, 32'h1);
    repeat (8) tick();
    rd_chk("status to",  32'h04, 32'ha);
    rd_chk("cycle to",   32'h08, 32'd5);
    wr_chk("clr to", 32'h04, 32'h8);
    rd_chk("status clr", 32'h04, 32'h0);
    wr_chk("limit off", 32'h0c, 32'd0);

    // start while running, then abort with both bits set
    wr_chk("abort idle", 32'h00, 32'h3);
    chk("no start both", stream_start, 32'd0);
    wr_chk("start2", 32'h00, 32'h1);
    tick();
    wr_chk("start err", 32'h00, 32'h1);
    rd_chk("status err", 32'h04, 32'h11);
    wr_chk("abort", 32'h00, 32'h3);
    rd_chk("status abort", 32'h04, 32'h12);
    wr_chk("clr all", 32'h04, 32'h1c);
    rd_chk("status clr2", 32'h04, 32'h0);

    // reset in the middle of a run
    wr_chk("limit7", 32'h0c, 32'd7);
    wr_chk("start3", 32'h00, 32'h1);
    repeat (3) tick();
    sync_rst = 1'b1; stream_finished = 1'b1; tst_rd = 1'b1; tst_addr = 32'h04;
    tick();
    chk("mid rst ack",    tst_ack,          32'd0);
    chk("mid rst active", streaming_active, 32'd0);
    chk("mid rst start",  stream_start,     32'd0);
    sync_rst = 1'b0; stream_finished = 1'b0; tst_rd = 1'b0;
    rd_chk("rst status", 32'h04, 32'h0);
    rd_chk("rst limit",  32'h0c, 32'h0);
    rd_chk("rst cycle",  32'h08, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cl_stream_ctl_slv.md
Name: cl_stream_ctl_slv

Overview:
- Register-slot consumer for one 256 B slot of the OCL slave decode.
- Takes the one-cycle test-slot write/read pulses (addr, wdata) and returns a one-cycle ack with read data.
- Holds the streaming control FSM (start/abort/finish/timeout), a run-cycle counter and a beat counter.
- Drives streaming_active and stream_start to the streaming datapath.

Parameters:
- DEFAULT_TIMEOUT, 32'd0, reset value of TIMEOUT_LIMIT (0 = timeout disabled).
- UNMAPPED_RDATA, 32'hdead_beef, read data returned for unmapped offsets.

Ports:
- clk  in  1  clock; single clock domain.
- sync_rst  in  1  reset; synchronous, active-high.
- tst_addr  in  32  request address; only [7:2] decoded, [1:0] ignored.
- tst_wdata  in  32  write data; valid with tst_wr.
- tst_wr  in  1  one-cycle write request pulse.
- tst_rd  in  1  one-cycle read request pulse.
- tst_ack  out  1  one-cycle completion pulse.
- tst_rdata  out  32  read data; valid while tst_ack=1.
- beat_valid  in  1  one pulse per streamed beat.
- stream_finished  in  1  datapath completion pulse.
- stream_start  out  1  one-cycle start pulse to datapath.
- streaming_active  out  1  high while FSM is in RUN.

Behaviour:
- Reset: state=IDLE; tst_ack, tst_rdata, stream_start, streaming_active, all counters and sticky bits = 0; TIMEOUT_LIMIT=DEFAULT_TIMEOUT; SCRATCH=0.
- Register map (byte offset = tst_addr[7:0]):
  - 0x00 CTRL (W): bit0 start, bit1 abort; both self-clearing. Reads 0.
  - 0x04 STATUS (R/W1C): [1:0] state (IDLE=0, RUN=1, DONE=2), [2] done, [3] timeout, [4] start_err, [31:5]=0. W1C affects bits [4:2] only.
  - 0x08 CYCLE_CNT (RO).
  - 0x0C TIMEOUT_LIMIT (RW).
  - 0x10 BEAT_CNT (RO).
  - 0x14 SCRATCH (RW).
  - Other offsets: write ignored, read returns UNMAPPED_RDATA; always acked.
- Ack latency: exactly 1 cycle. tst_ack and tst_rdata are registered on the edge after the request. Writes take effect on that same edge.
- A request is accepted on every cycle, so back-to-back pulses produce back-to-back acks.
- tst_wr and tst_rd high together: the write is performed, tst_rdata returns the pre-write value of the read offset, and a single ack is issued.
- FSM:
  - IDLE / DONE -> RUN on a CTRL write with bit0=1 (bit1=0). On the same edge: CYCLE_CNT=0, BEAT_CNT=0, done=0, timeout=0, stream_start=1 for exactly one cycle.
  - CTRL start while in RUN: ignored; start_err set.
  - In RUN, evaluated each cycle with priority abort > stream_finished > timeout:
    - Abort write -> DONE, done=0, timeout=0.
    - stream_finished=1 -> DONE, done=1.
    - TIMEOUT_LIMIT!=0 and CYCLE_CNT>=TIMEOUT_LIMIT -> DONE, timeout=1.
    - Otherwise CYCLE_CNT increments, saturating at 32'hffff_ffff.
  - CTRL bits 0 and 1 both set: abort wins; no start.
  - Abort in IDLE/DONE: no effect.
  - DONE -> IDLE on a STATUS write with bit2=1 or bit3=1.
  - stream_finished outside RUN: ignored.
- streaming_active = (state==RUN), registered.
- BEAT_CNT increments on beat_valid only while in RUN, saturating. CYCLE_CNT and BEAT_CNT hold their values in DONE/IDLE until the next start.
- A read of CYCLE_CNT/BEAT_CNT returns the value registered before the counting edge.
- Reset asserted mid-RUN: everything returns to reset values next edge; no stream_start, no pending ack.

Test Plan:
- Reset, then read 0x04, 0x0C, 0x3C -> acks 1 cycle after each pulse; rdata 0x0, 0x0, 0xdead_beef.
- Write SCRATCH 0xa5a5_1234, read back same cycle+1 -> ack then rdata 0xa5a5_1234; write 0x3C -> ack, no register change.
- Write CTRL=1 -> stream_start high 1 cycle, streaming_active=1. 10 beat_valid pulses, stream_finished after 20 cycles -> STATUS reads 0x6 (DONE, done=1), BEAT_CNT=10, CYCLE_CNT=20 ±0 per the increment rule.
- TIMEOUT_LIMIT=5, CTRL=1, no finish -> DONE after CYCLE_CNT reaches 5; STATUS=0xA; write STATUS 0x8 -> STATUS=0x0 (IDLE).
- In RUN, write CTRL=1 -> STATUS bit4 set, still RUN. Then CTRL=3 -> DONE with done=0, timeout=0.
- Assert sync_rst mid-RUN with a simultaneous stream_finished -> next cycle: streaming_active=0, STATUS=0, TIMEOUT_LIMIT=DEFAULT_TIMEOUT, tst_ack=0.
